// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard control bundle between the pipeline datapath and its controller.
// master = datapath (hazard sources, consumes cond); slave = controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             id_jump;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic [1:0]       pc_cond;
  logic [1:0]       ifid_cond;
  logic [1:0]       idex_cond;
  logic [1:0]       exmem_cond;
  logic             redirect_en;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt,
    output ex_memread, ex_rt,
    output id_jump, ex_branch_taken, mem_busy,
    input  pc_cond, ifid_cond, idex_cond,
    input  exmem_cond, redirect_en,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt,
    input  ex_memread, ex_rt,
    input  id_jump, ex_branch_taken, mem_busy,
    output pc_cond, ifid_cond, idex_cond,
    output exmem_cond, redirect_en,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, memory
// freeze with deferred redirect replay. Ports: clk, reset, hz (slave).
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN,
    LU_BUBBLE,
    FREEZE,
    REPLAY
  } state_t;

  // cond encoding: 0 flush, 1 load, 2 hold
  // packed as {pc, ifid, idex, exmem}
  localparam logic [7:0] P_RST  = 8'b00_00_00_00;
  localparam logic [7:0] P_RUN  = 8'b01_01_01_01;
  localparam logic [7:0] P_HOLD = 8'b10_10_10_10;
  localparam logic [7:0] P_LU   = 8'b10_10_00_01;
  localparam logic [7:0] P_BR   = 8'b01_00_00_01;
  localparam logic [7:0] P_JMP  = 8'b01_00_01_01;

  localparam logic [CNT_W-1:0] CNT_MAX =
    {CNT_W{1'b1}};

  state_t     state_q, state_d;
  logic       pend_q, pend_d;
  logic       pend_br_q, pend_br_d;
  logic [7:0] cond;
  logic       redir;
  logic       lu;
  logic       redir_in;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign lu = hz.ex_memread
           && (hz.ex_rt != 5'd0)
           && ((hz.ex_rt == hz.id_rs)
            || (hz.id_uses_rt
             && (hz.ex_rt == hz.id_rt)));

  assign redir_in = hz.ex_branch_taken
                 || hz.id_jump;

  always_comb begin
    cond      = P_RUN;
    redir     = 1'b0;
    state_d   = state_q;
    pend_d    = pend_q;
    pend_br_d = pend_br_q;
    if (reset) begin
      cond    = P_RST;
      state_d = RUN;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        RUN, LU_BUBBLE: begin
          state_d = RUN;
          if (hz.mem_busy) begin
            cond    = P_HOLD;
            state_d = FREEZE;
            if (redir_in) begin
              pend_d    = 1'b1;
              pend_br_d = hz.ex_branch_taken;
            end
          end else if (hz.ex_branch_taken) begin
            cond  = P_BR;
            redir = 1'b1;
          end else if (hz.id_jump) begin
            cond  = P_JMP;
            redir = 1'b1;
          end else if (lu && state_q == RUN) begin
            // the bubble cycle lets the load
            // advance, so no second stall
            cond    = P_LU;
            state_d = LU_BUBBLE;
          end
        end
        FREEZE: begin
          // hold also in the exit cycle
          cond = P_HOLD;
          if (hz.mem_busy) begin
            if (redir_in) begin
              pend_d    = 1'b1;
              pend_br_d = hz.ex_branch_taken;
            end
          end else begin
            state_d = pend_q ? REPLAY : RUN;
          end
        end
        REPLAY: begin
          if (hz.mem_busy) begin
            cond    = P_HOLD;
            state_d = FREEZE;
            if (redir_in) begin
              pend_br_d = hz.ex_branch_taken;
            end
          end else begin
            cond    = pend_br_q ? P_BR : P_JMP;
            redir   = 1'b1;
            pend_d  = 1'b0;
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    pend_q    <= pend_d;
    pend_br_q <= pend_br_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (cond[7:6] == 2'd2
          && stall_q != CNT_MAX) begin
        stall_q <= stall_q + 1'b1;
      end
      if (cond[5:4] == 2'd0
          && flush_q != CNT_MAX) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign hz.pc_cond     = cond[7:6];
  assign hz.ifid_cond   = cond[5:4];
  assign hz.idex_cond   = cond[3:2];
  assign hz.exmem_cond  = cond[1:0];
  assign hz.redirect_en = redir;
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Checks {redirect_en, pc, ifid, idex, exmem} and counters.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hw ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  hn ();

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .hz(hw)
  );

  pipeline_hazard_ctrl #(.CNT_W(2)) dut_n (
    .clk(clk), .reset(reset), .hz(hn)
  );

  localparam logic [8:0] O_RST  = 9'b0_00_00_00_00;
  localparam logic [8:0] O_RUN  = 9'b0_01_01_01_01;
  localparam logic [8:0] O_HOLD = 9'b0_10_10_10_10;
  localparam logic [8:0] O_LU   = 9'b0_10_10_00_01;
  localparam logic [8:0] O_BR   = 9'b1_01_00_00_01;
  localparam logic [8:0] O_JMP  = 9'b1_01_00_01_01;

  function automatic logic [8:0] outs();
    return {hw.redirect_en, hw.pc_cond,
            hw.ifid_cond, hw.idex_cond,
            hw.exmem_cond};
  endfunction

  task automatic set_in(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic uses, input logic memrd,
    input logic [4:0] exrt, input logic jmp,
    input logic br, input logic busy);
    hw.id_rs = rs; hn.id_rs = rs;
    hw.id_rt = rt; hn.id_rt = rt;
    hw.id_uses_rt = uses; hn.id_uses_rt = uses;
    hw.ex_memread = memrd; hn.ex_memread = memrd;
    hw.ex_rt = exrt; hn.ex_rt = exrt;
    hw.id_jump = jmp; hn.id_jump = jmp;
    hw.ex_branch_taken = br;
    hn.ex_branch_taken = br;
    hw.mem_busy = busy; hn.mem_busy = busy;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_in(5, 5, 1, 1, 5, 1, 1, 1);
    #1;
    checks++;
    if (outs() !== O_RST) begin
      errors++;
      $display("FAIL rst_outs got %b want %b",
               outs(), O_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL rst_run got %b want %b",
               outs(), O_RUN);
    end
    checks++;
    if (hw.stall_cnt !== 16'd0
        || hw.flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_cnt got %0d/%0d want 0/0",
               hw.stall_cnt, hw.flush_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(5, 0, 0, 1, 5, 0, 0, 0);
    #1;
    checks++;
    if (outs() !== O_LU) begin
      errors++;
      $display("FAIL lu_stall got %b want %b",
               outs(), O_LU);
    end
    @(negedge clk);
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL lu_bubble got %b want %b",
               outs(), O_RUN);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (hw.stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_cnt got %0d want 1",
               hw.stall_cnt);
    end
    set_in(1, 7, 1, 1, 7, 0, 0, 0);
    #1;
    checks++;
    if (outs() !== O_LU) begin
      errors++;
      $display("FAIL lu_rt got %b want %b",
               outs(), O_LU);
    end
    @(negedge clk);
    @(negedge clk);
    set_in(1, 7, 0, 1, 7, 0, 0, 0);
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL lu_rt_unused got %b want %b",
               outs(), O_RUN);
    end
    set_in(0, 0, 1, 1, 0, 0, 0, 0);
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL lu_r0 got %b want %b",
               outs(), O_RUN);
    end
    @(negedge clk);
    #1;
    checks++;
    if (hw.stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL lu_r0_cnt got %0d want 2",
               hw.stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(3, 0, 0, 1, 3, 0, 0, 0);
    #1;
    checks++;
    if (outs() !== O_LU) begin
      errors++;
      $display("FAIL b2b_1 got %b want %b",
               outs(), O_LU);
    end
    @(negedge clk);
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL b2b_2 got %b want %b",
               outs(), O_RUN);
    end
    @(negedge clk);
    #1;
    checks++;
    if (outs() !== O_LU) begin
      errors++;
      $display("FAIL b2b_3 got %b want %b",
               outs(), O_LU);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    set_in(5, 0, 0, 1, 5, 0, 1, 0);
    #1;
    checks++;
    if (outs() !== O_BR) begin
      errors++;
      $display("FAIL br_lu got %b want %b",
               outs(), O_BR);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (outs() !== O_RUN
        || hw.flush_cnt !== 16'd1
        || hw.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL br_after got %b f%0d s%0d want %b f1 s0",
               outs(), hw.flush_cnt,
               hw.stall_cnt, O_RUN);
    end
    set_in(5, 0, 0, 1, 5, 1, 0, 0);
    #1;
    checks++;
    if (outs() !== O_JMP) begin
      errors++;
      $display("FAIL jmp_lu got %b want %b",
               outs(), O_JMP);
    end
    set_in(0, 0, 0, 0, 0, 1, 1, 0);
    #1;
    checks++;
    if (outs() !== O_BR) begin
      errors++;
      $display("FAIL br_over_jmp got %b want %b",
               outs(), O_BR);
    end
  endtask

  task automatic test_freeze_replay();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outs() !== O_HOLD) begin
        errors++;
        $display("FAIL frz_hold%0d got %b want %b",
                 i, outs(), O_HOLD);
      end
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0, 0, i < 2);
    end
    #1;
    checks++;
    if (outs() !== O_BR) begin
      errors++;
      $display("FAIL frz_replay got %b want %b",
               outs(), O_BR);
    end
    @(negedge clk);
    #1;
    checks++;
    if (outs() !== O_RUN
        || hw.stall_cnt !== 16'd4
        || hw.flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL frz_run got %b s%0d f%0d want %b s4 f1",
               outs(), hw.stall_cnt,
               hw.flush_cnt, O_RUN);
    end
    set_in(0, 0, 0, 0, 0, 1, 0, 1);
    @(negedge clk);
    idle();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (outs() !== O_HOLD) begin
      errors++;
      $display("FAIL rep_busy got %b want %b",
               outs(), O_HOLD);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (outs() !== O_HOLD) begin
      errors++;
      $display("FAIL rep_exit got %b want %b",
               outs(), O_HOLD);
    end
    @(negedge clk);
    #1;
    checks++;
    if (outs() !== O_JMP) begin
      errors++;
      $display("FAIL rep_jmp got %b want %b",
               outs(), O_JMP);
    end
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    checks++;
    if (outs() !== O_RUN) begin
      errors++;
      $display("FAIL frz_nopend got %b want %b",
               outs(), O_RUN);
    end
  endtask

  task automatic test_reset_freeze();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== O_RST) begin
      errors++;
      $display("FAIL rstfrz_outs got %b want %b",
               outs(), O_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (outs() !== O_RUN
          || hw.stall_cnt !== 16'd0
          || hw.flush_cnt !== 16'd0) begin
        errors++;
        $display("FAIL rstfrz_run%0d got %b s%0d f%0d want %b s0 f0",
                 i, outs(), hw.stall_cnt,
                 hw.flush_cnt, O_RUN);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(9, 0, 0, 1, 9, 0, 0, 0);
      @(negedge clk);
      idle();
      @(negedge clk);
    end
    #1;
    checks++;
    if (hn.stall_cnt !== 2'd3
        || hw.stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL sat_stall got %0d/%0d want 3/5",
               hn.stall_cnt, hw.stall_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
    end
    idle();
    #1;
    checks++;
    if (hn.flush_cnt !== 2'd3
        || hw.flush_cnt !== 16'd5) begin
      errors++;
      $display("FAIL sat_flush got %0d/%0d want 3/5",
               hn.flush_cnt, hw.flush_cnt);
    end
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_back_to_back();
    test_redirect();
    test_freeze_replay();
    test_reset_freeze();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
